ddr_app_bram_responder: RTL and testbench

Synthesizable responder for the MIG-style DDR3 application (UI) interface. It plays the memory-controller side that the DDR write/read FSM initiates against: it accepts app_en/app_cmd/app_addr and write data, stores data in on-chip block RAM, and returns read data in order with fixed latency. It is used for DDR-less loopback builds and for FSM regression.
Calibration delay and optional pseudo-random backpressure reproduce the controller handshakes.

---
 rtl/ddr_app_pkg.sv | 27 ++
 rtl/ddr_resp_sync_fifo.sv | 58 +++++
 rtl/ddr_app_bram_responder.sv | 158 +++++++++++++++
 tb/tb_ddr_app_bram_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr_app_pkg
// Brief   : Shared constants, queue entry type and LFSR step for the DDR UI
//           BRAM responder.
// Rev     : 1.0  initial release
// ============================================================================
package ddr_app_pkg;

    localparam logic [2:0]  CMD_WRITE      = 3'b000;
    localparam logic [2:0]  CMD_READ       = 3'b001;
    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form over bits 15/13/12/10
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam int          APP_ADDR_WIDTH = 30;

    typedef struct packed {
        logic [2:0]                cmd;
        logic [APP_ADDR_WIDTH-1:0] addr;
    } cmd_entry_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_resp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ddr_resp_sync_fifo
// Brief   : Single-clock FIFO with count/full/empty; head is shown unregistered.
// Rev     : 1.0  initial release
// ============================================================================
module ddr_resp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    // A pop on a full queue frees the slot for a push in the same edge
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/ddr_app_bram_responder.sv
`default_nettype none
// ============================================================================
// Module  : ddr_app_bram_responder
// Brief   : MIG-style DDR3 UI responder backed by block RAM, in-order reads.
// Rev     : 1.0  initial release
// ============================================================================
module ddr_app_bram_responder
    import ddr_app_pkg::*;
#(
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 256,
    parameter int MEM_AW       = 10,
    parameter int CMD_DEPTH    = 8,
    parameter int WDAT_DEPTH   = 8,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 1000,
    parameter int STALL_EN     = 0
) (
    input  logic                  ddr_ui_clk,
    input  logic                  ddr_log_rst,
    input  logic [ADDR_WIDTH-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [DATA_WIDTH-1:0] app_wdf_data,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  init_calib_complete,
    output logic                  protocol_err
);

    localparam int CW = $clog2(CALIB_CYCLES + 1);

    logic [CW-1:0]            calib_cnt_q;
    logic                     calib_q;
    logic                     err_q, err_d;
    logic                     stall_c, stall_w;
    cmd_entry_t               cmd_in, cmd_head;
    logic                     cmd_full, cmd_empty, wdat_full, wdat_empty;
    logic [$clog2(CMD_DEPTH):0]  cmd_cnt;
    logic [$clog2(WDAT_DEPTH):0] wdat_cnt;
    logic [DATA_WIDTH-1:0]    wdat_head;
    logic                     cmd_acc, cmd_legal, cmd_push, wdat_push;
    logic                     exec_wr, exec_rd;
    logic [MEM_AW-1:0]        mem_idx;
    logic [DATA_WIDTH-1:0]    bram_q [2**MEM_AW];
    logic [DATA_WIDTH-1:0]    bram_rd_q;
    logic                     rd_v0_q;
    logic [RD_LATENCY:0]      pipe_v_q;
    logic [DATA_WIDTH-1:0]    pipe_d_q [RD_LATENCY+1];
    logic                     unused_bits;

    always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
        if (ddr_log_rst) begin
            calib_cnt_q <= '0;
            calib_q     <= 1'b0;
        end else if (!calib_q) begin
            calib_cnt_q <= calib_cnt_q + CW'(1);
            if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
        end
    end

    generate
        if (STALL_EN != 0) begin : g_stall
            logic [15:0] lfsr_q;
            always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
                if (ddr_log_rst) lfsr_q <= LFSR_SEED;
                else             lfsr_q <= lfsr_next(lfsr_q);
            end
            assign stall_c = (lfsr_q[3:0] == 4'd0);
            assign stall_w = (lfsr_q[7:4] == 4'd0);
        end else begin : g_no_stall
            assign stall_c = 1'b0;
            assign stall_w = 1'b0;
        end
    endgenerate

    assign app_rdy     = calib_q & ~cmd_full  & ~stall_c;
    assign app_wdf_rdy = calib_q & ~wdat_full & ~stall_w;

    assign cmd_acc    = app_en & app_rdy;
    assign cmd_legal  = (app_cmd == CMD_WRITE) || (app_cmd == CMD_READ);
    assign cmd_push   = cmd_acc & cmd_legal;
    assign wdat_push  = app_wdf_wren & app_wdf_rdy;
    assign cmd_in.cmd  = app_cmd;
    assign cmd_in.addr = app_addr;

    assign err_d = err_q | (cmd_acc & ~cmd_legal) | (wdat_push & ~app_wdf_end)
                 | (~calib_q & (app_en | app_wdf_wren));

    always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
        if (ddr_log_rst) err_q <= 1'b0;
        else             err_q <= err_d;
    end
    assign protocol_err = err_q;

    ddr_resp_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_q (
        .clk_i   (ddr_ui_clk),
        .rst_i   (ddr_log_rst),
        .push_i  (cmd_push),
        .din_i   (cmd_in),
        .pop_i   (exec_wr | exec_rd),
        .dout_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_cnt)
    );

    ddr_resp_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(WDAT_DEPTH)) u_wdat_q (
        .clk_i   (ddr_ui_clk),
        .rst_i   (ddr_log_rst),
        .push_i  (wdat_push),
        .din_i   (app_wdf_data),
        .pop_i   (exec_wr),
        .dout_o  (wdat_head),
        .full_o  (wdat_full),
        .empty_o (wdat_empty),
        .count_o (wdat_cnt)
    );

    // A write at the head waits for its beat; a read never waits
    assign exec_wr = ~cmd_empty & (cmd_head.cmd == CMD_WRITE) & ~wdat_empty;
    assign exec_rd = ~cmd_empty & (cmd_head.cmd == CMD_READ);
    assign mem_idx = cmd_head.addr[MEM_AW+2:3];

    always_ff @(posedge ddr_ui_clk) begin
        if (exec_wr) bram_q[mem_idx] <= wdat_head;
        if (exec_rd) bram_rd_q <= bram_q[mem_idx];
    end

    always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
        if (ddr_log_rst) begin
            rd_v0_q  <= 1'b0;
            pipe_v_q <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) pipe_d_q[k] <= '0;
        end else begin
            rd_v0_q     <= exec_rd;
            pipe_v_q[0] <= rd_v0_q;
            if (rd_v0_q) pipe_d_q[0] <= bram_rd_q;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                pipe_v_q[k] <= pipe_v_q[k-1];
                if (pipe_v_q[k-1]) pipe_d_q[k] <= pipe_d_q[k-1];
            end
        end
    end

    assign app_rd_data         = pipe_d_q[RD_LATENCY];
    assign app_rd_data_valid   = pipe_v_q[RD_LATENCY];
    assign init_calib_complete = calib_q;

    assign unused_bits = ^{cmd_head.addr[2:0], cmd_head.addr[ADDR_WIDTH-1:MEM_AW+3],
                           cmd_cnt, wdat_cnt};

endmodule
`default_nettype wire

// File: tb/tb_ddr_app_bram_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ddr_app_bram_responder
// Brief   : Self-checking bench: directed UI sequences plus randomized stall run.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ddr_app_bram_responder;

    localparam int AW = 30, DW = 256, RDL = 4, CAL = 1000;
    localparam logic [2:0] WR = 3'b000, RD = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic [DW-1:0] app_wdf_data, app_rd_data;
    logic          app_rd_data_valid, calib, perr;

    logic          rst_s, s_en, s_rdy, s_wren, s_end, s_wrdy;
    logic [AW-1:0] s_addr;
    logic [2:0]    s_cmd;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_rvalid, s_calib, s_perr;

    ddr_app_bram_responder #(.RD_LATENCY(RDL), .CALIB_CYCLES(CAL), .STALL_EN(0)) dut (
        .ddr_ui_clk(clk), .ddr_log_rst(rst), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(calib), .protocol_err(perr));

    ddr_app_bram_responder #(.RD_LATENCY(RDL), .CALIB_CYCLES(CAL), .STALL_EN(1)) dut_s (
        .ddr_ui_clk(clk), .ddr_log_rst(rst_s), .app_addr(s_addr), .app_cmd(s_cmd),
        .app_en(s_en), .app_rdy(s_rdy), .app_wdf_data(s_wdata),
        .app_wdf_wren(s_wren), .app_wdf_end(s_end), .app_wdf_rdy(s_wrdy),
        .app_rd_data(s_rdata), .app_rd_data_valid(s_rvalid),
        .init_calib_complete(s_calib), .protocol_err(s_perr));

    int            total = 0, bad = 0;
    longint        cyc = 0, v_first = 0, v_last = 0;
    int            v_cnt = 0, vs_cnt = 0, stall_lo = 0;
    logic [DW-1:0] ref_m [1024];
    logic [DW-1:0] ref_s [1024];
    bit            wr_s  [1024];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_qs[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a[12:3]);
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            if (exp_q.size() == 0) chk("unexp_valid", 1, 0);
            else chk("rd_data", app_rd_data, exp_q.pop_front());
            if (v_cnt == 0) v_first = cyc;
            v_last = cyc;
            v_cnt++;
        end
        if (s_rvalid) begin
            if (exp_qs.size() == 0) chk("unexp_valid_s", 1, 0);
            else chk("stall_rd", s_rdata, exp_qs.pop_front());
            vs_cnt++;
        end
        if (s_calib && !s_rdy) stall_lo++;
    end

    // Command and data handshakes complete independently; caller sits just after a posedge
    task automatic xfer(input bit dc, input logic [2:0] c, input logic [AW-1:0] a,
                        input bit dw, input logic [DW-1:0] d, input bit e);
        bit cd = !dc, wd = !dw;
        int t = 0;
        app_en = dc; app_cmd = c; app_addr = a;
        app_wdf_wren = dw; app_wdf_data = d; app_wdf_end = e;
        while (!(cd && wd)) begin
            @(negedge clk);
            if (app_en && app_rdy) cd = 1;
            if (app_wdf_wren && app_wdf_rdy) wd = 1;
            @(posedge clk); #1;
            if (cd) app_en = 0;
            if (wd) app_wdf_wren = 0;
            if (++t > 200) begin
                chk("hs_timeout", 0, 1);
                cd = 1; wd = 1; app_en = 0; app_wdf_wren = 0;
            end
        end
    endtask

    task automatic xfer_s(input bit dc, input logic [2:0] c, input logic [AW-1:0] a,
                          input bit dw, input logic [DW-1:0] d);
        bit cd = !dc, wd = !dw;
        int t = 0;
        s_en = dc; s_cmd = c; s_addr = a; s_wren = dw; s_wdata = d; s_end = 1'b1;
        while (!(cd && wd)) begin
            @(negedge clk);
            if (s_en && s_rdy) cd = 1;
            if (s_wren && s_wrdy) wd = 1;
            @(posedge clk); #1;
            if (cd) s_en = 0;
            if (wd) s_wren = 0;
            if (++t > 200) begin
                chk("hs_timeout_s", 0, 1);
                cd = 1; wd = 1; s_en = 0; s_wren = 0;
            end
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        xfer(1, WR, a, 1, d, 1);
        ref_m[widx(a)] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_q.push_back(ref_m[widx(a)]);
        xfer(1, RD, a, 0, '0, 1);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || exp_qs.size() != 0) && t < 300) begin
            @(posedge clk); t++;
        end
        #1;
        chk(tag, exp_q.size() + exp_qs.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, lat, idx, ridx;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        bit ok;
        rst = 1; rst_s = 1;
        app_en = 0; app_cmd = WR; app_addr = '0; app_wdf_wren = 0; app_wdf_end = 0; app_wdf_data = '0;
        s_en = 0; s_cmd = WR; s_addr = '0; s_wren = 0; s_end = 0; s_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", app_rdy, 0);
        chk("rst_wrdy", app_wdf_rdy, 0);
        chk("rst_valid", app_rd_data_valid, 0);
        chk("rst_rdata", app_rd_data, 0);
        chk("rst_calib", calib, 0);
        chk("rst_err", perr, 0);
        @(posedge clk); #1;
        rst = 0; rst_s = 0;

        // Calibration edge count; poke the stalling instance early for a pre-calib error
        for (int i = 1; i <= CAL - 1; i++) begin
            @(posedge clk);
            if (i == 1) begin #1 s_en = 1; end
            if (i == 2) begin #1 s_en = 0; end
        end
        @(negedge clk);
        chk("calib_early", calib, 0);
        chk("rdy_early", app_rdy, 0);
        chk("wrdy_early", app_wdf_rdy, 0);
        @(posedge clk);
        @(negedge clk);
        chk("calib_on", calib, 1);
        chk("rdy_on", app_rdy, 1);
        chk("wrdy_on", app_wdf_rdy, 1);
        chk("precal_err_s", s_perr, 1);
        chk("no_err", perr, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 128; i++) do_write(AW'(i * 8), {8{32'(i)}});
        v_cnt = 0;
        for (int i = 0; i < 128; i++) do_read(AW'(i * 8));
        wait_drain("b2b_drain");
        chk("b2b_count", v_cnt, 128);
        chk("b2b_span", v_last - v_first, 127);

        repeat (10) @(posedge clk); #1;
        do_read(AW'('h40));
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!app_rd_data_valid && lat < 20);
        chk("rd_latency", lat, RDL + 2);
        @(posedge clk); #1;

        do_write(AW'('h40), rnd_data());
        do_read(AW'('h40));

        // Data ahead of its command; a read queued in between still sees old contents
        d = rnd_data();
        xfer(0, WR, '0, 1, d, 1);
        repeat (3) @(posedge clk); #1;
        do_read(AW'('h80));
        xfer(1, WR, AW'('h80), 0, '0, 1);
        ref_m[16] = d;
        do_read(AW'('h80));
        wait_drain("early_drain");

        repeat (12) @(posedge clk); #1;
        acc = 0;
        app_en = 1; app_cmd = WR;
        for (int t = 0; t < 20; t++) begin
            app_addr = AW'((512 + acc) * 8);
            @(negedge clk); ok = app_rdy;
            @(posedge clk); #1;
            if (ok) acc++;
        end
        @(negedge clk);
        chk("full_accepts", acc, 8);
        chk("full_rdy", app_rdy, 0);
        app_en = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            d = rnd_data();
            xfer(0, WR, '0, 1, d, 1);
            ref_m[512 + k] = d;
        end
        do_write(AW'((512 + 8) * 8), rnd_data());
        for (int k = 0; k < 9; k++) do_read(AW'((512 + k) * 8));
        wait_drain("full_drain");

        // Illegal command, then reset while a read is inside the return pipeline
        chk("err_pre", perr, 0);
        xfer(1, 3'b010, AW'('h40), 0, '0, 1);
        @(negedge clk);
        chk("err_set", perr, 1);
        @(posedge clk); #1;
        do_read(AW'('h40));
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_sticky", perr, 1);
        #1 rst = 1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_valid", app_rd_data_valid, 0);
        chk("mid_rst_err", perr, 0);
        chk("mid_rst_rdy", app_rdy, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (CAL + 2) @(posedge clk);
        @(negedge clk);
        chk("recal", calib, 1);
        chk("recal_rdy", app_rdy, 1);
        chk("recal_wrdy", app_wdf_rdy, 1);
        chk("recal_valid", app_rd_data_valid, 0);
        @(posedge clk); #1;
        do_read(AW'('h40));
        wait_drain("post_rst_drain");

        xfer(1, WR, AW'('h48), 1, d, 0);
        ref_m[9] = d;
        @(negedge clk);
        chk("wdf_end_err", perr, 1);
        @(posedge clk); #1;
        do_read(AW'('h48));
        wait_drain("end_err_drain");

        // Randomized traffic on the stalling instance, aliased through high address bits
        vs_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            idx = $urandom_range(0, 31);
            d = rnd_data();
            a = {17'($urandom), 10'(idx), 3'($urandom)};
            xfer_s(1, WR, a, 1, d);
            ref_s[idx] = d; wr_s[idx] = 1;
            ridx = $urandom_range(0, 31);
            if (!wr_s[ridx]) ridx = idx;
            exp_qs.push_back(ref_s[ridx]);
            xfer_s(1, RD, {17'($urandom), 10'(ridx), 3'($urandom)}, 0, '0);
        end
        wait_drain("stall_drain");
        chk("stall_count", vs_cnt, 1000);
        chk("stall_seen", stall_lo > 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
